// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared encodings for the PC redirect controller: RV32 opcode fields, PC mux selects and FSM states.
package pc_redirect_ctrl_pkg;

  // opcode[6:2] of JAL (1101111) and JALR (1100111)
  localparam logic [4:0] OPCODE_JAL  = 5'b11011;
  localparam logic [4:0] OPCODE_JALR = 5'b11001;

  localparam logic [1:0] PCSRC_JALR = 2'b00;
  localparam logic [1:0] PCSRC_TGT  = 2'b01;
  localparam logic [1:0] PCSRC_PC4  = 2'b10;
  localparam logic [1:0] PCSRC_HOLD = 2'b11;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IMEM_WAIT = 2'd1,
    REDIRECT  = 2'd2,
    HALTED    = 2'd3
  } state_t;

endpackage

// File: rtl/redirect_perf_cnt.sv
// Saturating stall/flush event counters for pc_redirect_ctrl.
// Only exists when PC_REDIRECT_PERF_CNT_EN is defined.
`ifdef PC_REDIRECT_PERF_CNT_EN
module redirect_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, stall);
      flush_cnt <= sat_inc(flush_cnt, flush);
    end
  end

endmodule
`endif

// File: rtl/pc_redirect_ctrl.sv
// PC select / pipeline stall-flush controller with fetch-timeout and halt handling.
// Optional perf counters (stall_cnt, flush_cnt) under PC_REDIRECT_PERF_CNT_EN.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int IMEM_TIMEOUT = 8,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [4:0]       ex_opcode,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             load_use,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic [1:0]       pc_src,
  output logic             pc_we,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic             imem_err
`ifdef PC_REDIRECT_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int TMO_W = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IMEM_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic [1:0]       pend_src, pend_src_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             imem_err_nxt;
  logic             is_jalr, redir_now, halt_now;
  logic [1:0]       redir_src;

  always_comb begin
    is_jalr   = (ex_opcode == OPCODE_JALR);
    redir_now = ex_valid & (is_jalr | (ex_opcode == OPCODE_JAL) | branch_taken);
    redir_src = is_jalr ? PCSRC_JALR : PCSRC_TGT;
    halt_now  = ex_valid & halt_req;
  end

  always_comb begin
    state_nxt      = state;
    pend_valid_nxt = pend_valid;
    pend_src_nxt   = pend_src;
    tmo_cnt_nxt    = tmo_cnt;
    imem_err_nxt   = imem_err;
    imem_req       = 1'b1;
    pc_src         = PCSRC_PC4;
    pc_we          = 1'b0;
    ifid_stall     = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;

    case (state)
      RUN: begin
        if (halt_now) begin
          imem_req   = 1'b0;
          pc_src     = PCSRC_HOLD;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          state_nxt  = HALTED;
        end else if (redir_now) begin
          pc_src     = redir_src;
          pc_we      = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_nxt  = REDIRECT;
        end else if (!imem_ack) begin
          pc_src      = PCSRC_HOLD;
          ifid_stall  = 1'b1;
          idex_flush  = 1'b1;
          tmo_cnt_nxt = '0;
          state_nxt   = IMEM_WAIT;
        end else if (load_use) begin
          pc_src     = PCSRC_HOLD;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end else begin
          pc_we = 1'b1;
        end
      end

      IMEM_WAIT: begin
        pc_src     = PCSRC_HOLD;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        if (halt_now) begin
          imem_req       = 1'b0;
          pend_valid_nxt = 1'b0;
          state_nxt      = HALTED;
        end else if (imem_ack) begin
          ifid_stall = 1'b0;
          pc_we      = 1'b1;
          if (pend_valid || redir_now) begin
            pc_src         = pend_valid ? pend_src : redir_src;
            ifid_flush     = 1'b1;
            pend_valid_nxt = 1'b0;
            state_nxt      = REDIRECT;
          end else begin
            pc_src     = PCSRC_PC4;
            idex_flush = 1'b0;
            state_nxt  = RUN;
          end
        end else begin
          // First redirect seen while waiting is the one replayed on ack.
          if (redir_now && !pend_valid) begin
            pend_valid_nxt = 1'b1;
            pend_src_nxt   = redir_src;
          end
          if (tmo_cnt == TMO_LAST) begin
            imem_err_nxt   = 1'b1;
            pend_valid_nxt = 1'b0;
            state_nxt      = HALTED;
          end else begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
          end
        end
      end

      REDIRECT: begin
        // EX holds the flushed bubble, so ex_valid (and halt) is not looked at here.
        pc_we = imem_ack;
        if (imem_ack) begin
          state_nxt = RUN;
        end else begin
          tmo_cnt_nxt = '0;
          state_nxt   = IMEM_WAIT;
        end
      end

      HALTED: begin
        imem_req   = 1'b0;
        pc_src     = PCSRC_HOLD;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end

      default: state_nxt = RUN;
    endcase

    if (!rst_n) begin
      imem_req   = 1'b0;
      pc_src     = PCSRC_HOLD;
      pc_we      = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      pend_valid <= 1'b0;
      tmo_cnt    <= '0;
      imem_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_valid <= pend_valid_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      imem_err   <= imem_err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    pend_src <= pend_src_nxt;
  end

  assign halted = (state == HALTED);

`ifdef PC_REDIRECT_PERF_CNT_EN
  redirect_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (ifid_stall),
    .flush     (ifid_flush),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_pc_redirect_ctrl;

  localparam int TMO = 8;
  localparam int CW  = 32;
  localparam logic [4:0] JAL  = 5'b11011;
  localparam logic [4:0] JALR = 5'b11001;
  localparam logic [4:0] ALU  = 5'b01100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ex_valid, branch_taken, halt_req, load_use, imem_ack;
  logic [4:0]    ex_opcode;
  logic          imem_req, pc_we, ifid_stall, ifid_flush, idex_flush, halted, imem_err;
  logic [1:0]    pc_src;
`ifdef PC_REDIRECT_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  pc_redirect_ctrl #(.IMEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .branch_taken (branch_taken),
    .halt_req     (halt_req),
    .load_use     (load_use),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .pc_src       (pc_src),
    .pc_we        (pc_we),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .halted       (halted),
    .imem_err     (imem_err)
`ifdef PC_REDIRECT_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  typedef struct {
    string         name;
    int            cyc;
    logic [8:0]    vec;   // {imem_req, pc_src, pc_we, ifid_stall, ifid_flush, idex_flush, halted, imem_err}
    logic [CW-1:0] scnt;
    logic [CW-1:0] fcnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Behavioural model state
  bit            m_halted = 0, m_err = 0, m_waiting = 0, m_refetch = 0;
  int            m_wait_n = 0;
  logic [1:0]    m_pend[$];
  logic [CW-1:0] m_scnt = '0, m_fcnt = '0;

  task automatic step(input string nm, input logic r, input logic ev, input logic [4:0] op,
                      input logic bt, input logic hr, input logic lu, input logic ak);
    exp_t e;
    logic q, we, st, ff, ef;
    logic [1:0] src;
    bit redir, hlt;
    logic [1:0] rsrc;
    @(posedge clk);
    #1;
    rst_n = r; ex_valid = ev; ex_opcode = op; branch_taken = bt;
    halt_req = hr; load_use = lu; imem_ack = ak;
    cyc++;

    redir = ev && (op == JAL || op == JALR || bt);
    rsrc  = (op == JALR) ? 2'b00 : 2'b01;
    hlt   = ev && hr;
    q = 1; src = 2'b10; we = 0; st = 0; ff = 0; ef = 0;
    e.name = nm; e.cyc = cyc; e.scnt = m_scnt; e.fcnt = m_fcnt;
    e.vec[1] = m_halted; e.vec[0] = m_err;

    if (!r) begin
      q = 0; src = 2'b11; ff = 1; ef = 1;
      m_halted = 0; m_err = 0; m_waiting = 0; m_refetch = 0; m_wait_n = 0;
      m_pend.delete();
    end else if (m_halted) begin
      q = 0; src = 2'b11; st = 1; ef = 1;
    end else if (m_refetch) begin
      we = ak; m_refetch = 0;
      if (!ak) begin m_waiting = 1; m_wait_n = 0; end
    end else if (hlt) begin
      q = 0; src = 2'b11; st = 1; ef = 1;
      m_halted = 1; m_waiting = 0; m_pend.delete();
    end else if (m_waiting) begin
      if (ak) begin
        we = 1; m_waiting = 0;
        if (m_pend.size() > 0 || redir) begin
          src = (m_pend.size() > 0) ? m_pend[0] : rsrc;
          ff = 1; ef = 1; m_refetch = 1; m_pend.delete();
        end
      end else begin
        src = 2'b11; st = 1; ef = 1;
        if (redir && m_pend.size() == 0) m_pend.push_back(rsrc);
        m_wait_n++;
        if (m_wait_n == TMO) begin
          m_err = 1; m_halted = 1; m_waiting = 0; m_pend.delete();
        end
      end
    end else if (redir) begin
      src = rsrc; we = 1; ff = 1; ef = 1; m_refetch = 1;
    end else if (!ak) begin
      src = 2'b11; st = 1; ef = 1; m_waiting = 1; m_wait_n = 0;
    end else if (lu) begin
      src = 2'b11; st = 1; ef = 1;
    end else begin
      we = 1;
    end

    e.vec[8:2] = {q, src, we, st, ff, ef};
    if (!r) begin
      m_scnt = '0; m_fcnt = '0;
    end else begin
      if (st && m_scnt != '1) m_scnt = m_scnt + 1'b1;
      if (ff && m_fcnt != '1) m_fcnt = m_fcnt + 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input string nm, input int n);
    for (int i = 0; i < n; i++) step(nm, 1, 0, ALU, 0, 0, 0, 1);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [8:0] got;
      e = sb.pop_front();
      got = {imem_req, pc_src, pc_we, ifid_stall, ifid_flush, idex_flush, halted, imem_err};
      checks++;
      if (got !== e.vec) begin
        errors++;
        $display("FAIL %s cyc=%0d {req,src,we,stall,ifl,efl,halted,err} got=%b required=%b",
                 e.name, e.cyc, got, e.vec);
      end
`ifdef PC_REDIRECT_PERF_CNT_EN
      checks++;
      if (stall_cnt !== e.scnt || flush_cnt !== e.fcnt) begin
        errors++;
        $display("FAIL %s_cnt cyc=%0d stall/flush got=%0d/%0d required=%0d/%0d",
                 e.name, e.cyc, stall_cnt, flush_cnt, e.scnt, e.fcnt);
      end
`endif
    end
  end

  initial begin
    int ack_pct;
    rst_n = 0; ex_valid = 0; ex_opcode = ALU; branch_taken = 0;
    halt_req = 0; load_use = 0; imem_ack = 1;

    step("reset", 0, 0, ALU, 0, 0, 0, 1);
    step("reset", 0, 0, ALU, 0, 0, 0, 1);
    idle("normal", 5);

    step("jal", 1, 1, JAL, 0, 0, 0, 1);
    step("jal_shadow_bt", 1, 1, ALU, 1, 0, 0, 1);
    idle("after_jal", 2);

    step("ack_lo1", 1, 0, ALU, 0, 0, 0, 0);
    step("ack_lo2_jalr", 1, 1, JALR, 0, 0, 0, 0);
    step("ack_lo3", 1, 0, ALU, 0, 0, 0, 0);
    step("ack_jalr_apply", 1, 0, ALU, 0, 0, 0, 1);
    idle("after_jalr", 2);

    step("load_use1", 1, 0, ALU, 0, 0, 1, 1);
    step("load_use2", 1, 0, ALU, 0, 0, 1, 1);
    idle("after_lu", 2);

    step("halt_bt", 1, 1, ALU, 1, 1, 0, 1);
    idle("halted", 3);
    step("reset_halt", 0, 0, ALU, 0, 0, 0, 1);
    idle("post_reset", 3);

    for (int i = 0; i < TMO + 3; i++) step("timeout", 1, 0, ALU, 0, 0, 0, 0);
    idle("timeout_halted", 2);
    step("reset_err", 0, 0, ALU, 0, 0, 0, 1);
    idle("post_reset_err", 2);

    for (int i = 0; i < TMO; i++) step("ack_at_limit_wait", 1, 0, ALU, 0, 0, 0, 0);
    step("ack_at_limit", 1, 0, ALU, 0, 0, 0, 1);
    idle("after_limit", 2);

    step("pend_wait", 1, 0, ALU, 0, 0, 0, 0);
    step("pend_jal", 1, 1, JAL, 0, 0, 0, 0);
    step("pend_jalr_ignored", 1, 1, JALR, 0, 0, 0, 0);
    step("pend_apply", 1, 0, ALU, 0, 0, 0, 1);
    idle("after_pend", 1);

    step("abandon_wait", 1, 0, ALU, 0, 0, 0, 0);
    step("abandon_jal", 1, 1, JAL, 0, 0, 0, 0);
    step("abandon_reset", 0, 0, ALU, 0, 0, 0, 0);
    idle("abandon_after", 2);

    ack_pct = 75;
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] op;
      if (i % 200 == 0) begin
        case ($urandom_range(2))
          0:       ack_pct = 20;
          1:       ack_pct = 75;
          default: ack_pct = 97;
        endcase
      end
      case ($urandom_range(3))
        0:       op = JAL;
        1:       op = JALR;
        default: op = 5'($urandom_range(31));
      endcase
      step("random", logic'($urandom_range(49) != 0), logic'($urandom_range(1)), op,
           logic'($urandom_range(4) == 0), logic'($urandom_range(99) == 0),
           logic'($urandom_range(6) == 0), logic'($urandom_range(99) < ack_pct));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter IMEM_TIMEOUT, default 8, the maximum number of IMEM_WAIT cycles before an error is raised.
REQ-002 SHALL have parameter CNT_W, default 32, the performance-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-005 SHALL have port ex_valid, input, 1, EX holds a valid instruction.
REQ-006 SHALL have port ex_opcode, input, 5, EX opcode[6:2].
REQ-007 SHALL have port branch_taken, input, 1, EX conditional branch resolved taken.
REQ-008 SHALL have port halt_req, input, 1, EX instruction is ecall/ebreak.
REQ-009 SHALL have port load_use, input, 1, ID load-use hazard detected.
REQ-010 SHALL have port imem_req, output, 1, fetch request.
REQ-011 SHALL have port imem_ack, input, 1, fetch data valid.
REQ-012 SHALL have port pc_src, output, 2, PC mux select: 00 jalr target, 01 branch/jal target, 10 PC+4, 11 hold.
REQ-013 SHALL have port pc_we, output, 1, PC register write enable.
REQ-014 SHALL have port ifid_stall, output, 1, hold IF/ID.
REQ-015 SHALL have port ifid_flush, output, 1, bubble IF/ID.
REQ-016 SHALL have port idex_flush, output, 1, bubble ID/EX.
REQ-017 SHALL have port halted, output, 1, core halted (sticky).
REQ-018 SHALL have port imem_err, output, 1, fetch timeout (sticky).

Function
REQ-019 SHALL implement FSM states RUN, IMEM_WAIT, REDIRECT and HALTED, with outputs decoded combinationally from the state and the current inputs.
REQ-020 SHALL define a redirect as ex_valid & (opcode==JALR | opcode==JAL | branch_taken), with pc_src=00 when the opcode is JALR and 01 otherwise.
REQ-021 SHALL apply this priority per cycle: halt > redirect > fetch wait > load_use > normal.
REQ-022 SHALL, in RUN with imem_ack=1 and no other event, drive imem_req=1, pc_src=10 and pc_we=1 with no stall or flush.
REQ-023 SHALL, in RUN with a redirect, drive pc_src per REQ-020, pc_we=1, ifid_flush=1 and idex_flush=1, then go to REDIRECT.
REQ-024 SHALL, in REDIRECT, ignore ex_valid (the EX instruction is a flushed bubble), drive imem_req=1, pc_src=10 and pc_we=imem_ack, and return to RUN on ack or go to IMEM_WAIT otherwise.
REQ-025 SHALL, in RUN with imem_ack=0, drive pc_we=0, pc_src=11, ifid_stall=1 and idex_flush=1, clear the timeout counter and go to IMEM_WAIT.
REQ-026 SHALL, in IMEM_WAIT, hold imem_req=1 and drive pc_we=0, pc_src=11, ifid_stall=1 and idex_flush=1, and increment the timeout counter each cycle.
REQ-027 SHALL, when a redirect occurs during IMEM_WAIT, latch pend_valid and pend_src (the first redirect wins; later ones are ignored while pend_valid is set).
REQ-028 SHALL, on imem_ack in IMEM_WAIT, apply the pending redirect if present (per REQ-023, then clear pend_valid and go to REDIRECT), or otherwise drive pc_src=10 and pc_we=1 and go to RUN.
REQ-029 SHALL, when the timeout counter reaches IMEM_TIMEOUT without ack, set imem_err and go to HALTED; an ack in the same cycle as the timeout wins.
REQ-030 SHALL, on load_use in RUN with no higher-priority event, drive pc_we=0, pc_src=11, ifid_stall=1 and idex_flush=1, and stay in RUN.
REQ-031 SHALL, on ex_valid & halt_req in any state except HALTED, go to HALTED; halt_req in the same cycle as a redirect means halt wins and no PC write occurs.
REQ-032 SHALL, in HALTED, drive halted=1, pc_we=0, pc_src=11, imem_req=0, ifid_stall=1 and idex_flush=1, and leave HALTED only via reset.

Reset
REQ-033 SHALL, on any clock edge with rst_n=0, set state to RUN and clear pend_valid, the timeout counter, halted, imem_err and all counters.
REQ-034 SHALL, while rst_n=0, force pc_we=0, pc_src=11, imem_req=0, ifid_flush=1 and idex_flush=1.
REQ-035 SHALL treat a reset asserted mid-IMEM_WAIT or mid-HALTED as abandoning the pending fetch and any pending redirect.

Configuration
REQ-036 SHALL, with PC_REDIRECT_PERF_CNT_EN defined, add outputs stall_cnt and flush_cnt (CNT_W each), incremented on cycles where ifid_stall=1 and ifid_flush=1 respectively, saturating at all-ones.
REQ-037 SHALL, without PC_REDIRECT_PERF_CNT_EN, omit those ports and all counter logic.

Structure
REQ-038 SHALL place the PCSRC_JALR/PCSRC_TGT/PCSRC_PC4/PCSRC_HOLD encodings and the FSM state encodings in the shared defines file, alongside the existing OPCODE_JAL and OPCODE_JALR definitions.
REQ-039 SHALL implement the counters in one sub-module, redirect_perf_cnt, instantiated only under the macro.

Verification
REQ-040 SHALL cover: imem_ack=1 held, no events -> pc_src=10 and pc_we=1 every cycle.
REQ-041 SHALL cover: EX JAL -> that cycle pc_src=01 with both flushes=1; the next cycle a branch_taken with ex_valid=1 is ignored.
REQ-042 SHALL cover: ack low for 3 cycles while EX issues JALR on the 2nd -> no PC write until ack, then pc_src=00 and pc_we=1 with flushes on the ack cycle.
REQ-043 SHALL cover: ack never returns -> imem_err=1 and halted=1 after 8 wait cycles, with pc_we=0 thereafter.
REQ-044 SHALL cover: halt_req with a simultaneous branch_taken -> halted=1 and the PC is not written; rst_n=0 for one cycle -> state RUN with all flags cleared.
REQ-045 SHALL cover: load_use for 2 cycles -> ifid_stall=1, idex_flush=1 and pc_we=0 for exactly 2 cycles (stall_cnt=2 when the macro is defined).
